// File: rtl/data_stack_pkg.sv
// Shared defaults, derived widths and the operation decode for data_stack.
// Defining DATA_STACK_ERR_EN enables the sticky overflow/underflow flags.
package data_stack_pkg;

    localparam int DEF_NBDATA = 32;
    localparam int DEF_SDEPTH = 16;
    localparam int DEF_PTR_W  = $clog2(DEF_SDEPTH);
    localparam int DEF_CNT_W  = DEF_PTR_W + 1;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } stack_op_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Push together with pop on an empty stack degenerates to a plain push.
    function automatic stack_op_e decode_op(input logic push, input logic pop,
                                            input logic is_empty);
        if (push && pop && !is_empty)
            return OP_REPLACE;
        else if (push)
            return OP_PUSH;
        else if (pop)
            return OP_POP;
        else
            return OP_NONE;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module stack_ram
    import data_stack_pkg::*;
#(
    parameter int NBDATA = DEF_NBDATA,
    parameter int SDEPTH = DEF_SDEPTH,
    parameter int PTR_W  = ptr_width(SDEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [NBDATA-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [NBDATA-1:0] rdata
);

    logic [NBDATA-1:0] mem [SDEPTH];

    // NOTE: storage has no reset; validity is tracked by count in the parent,
    // so clearing the array would only cost a reset net to every bit.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Circular data stack with registered top-of-stack; tp always indexes the top.
// Optional sticky ovf/unf flags are built when DATA_STACK_ERR_EN is defined.
module data_stack
    import data_stack_pkg::*;
#(
    parameter int NBDATA = DEF_NBDATA,
    parameter int SDEPTH = DEF_SDEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [NBDATA-1:0]      din,
    input  logic                   err_clr,
    output logic [NBDATA-1:0]      tos,
    output logic [$clog2(SDEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   unf
);

    localparam int PTR_W = ptr_width(SDEPTH);
    localparam int CNT_W = cnt_width(SDEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SDEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [PTR_W-1:0]  tp, tp_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [NBDATA-1:0] tos_nxt;
    logic [NBDATA-1:0] below_top;
    logic [PTR_W-1:0]  waddr;
    logic              we;
    logic              armed;
    stack_op_e         op;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign op    = decode_op(push, pop, empty);

    stack_ram #(
        .NBDATA (NBDATA),
        .SDEPTH (SDEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (din),
        .raddr (tp - 1'b1),
        .rdata (below_top)
    );

    // armed stays low through the first edge after reset release, so an
    // operation presented on that edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            armed <= 1'b0;
        else
            armed <= 1'b1;
    end

    // NOTE: every output of this block gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        tos_nxt   = tos;
        we        = 1'b0;
        waddr     = tp;
        if (armed) begin
            unique case (op)
                OP_PUSH: begin
                    tp_nxt  = tp + 1'b1;
                    waddr   = tp + 1'b1;
                    we      = 1'b1;
                    tos_nxt = din;
                    if (!full)
                        count_nxt = count + 1'b1;
                end
                OP_REPLACE: begin
                    waddr   = tp;
                    we      = 1'b1;
                    tos_nxt = din;
                end
                OP_POP: begin
                    if (!empty) begin
                        tp_nxt    = tp - 1'b1;
                        count_nxt = count - 1'b1;
                        tos_nxt   = (count == ONE_CNT) ? '0 : below_top;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp    <= '0;
            count <= '0;
            tos   <= '0;
        end else begin
            tp    <= tp_nxt;
            count <= count_nxt;
            tos   <= tos_nxt;
        end
    end

`ifdef DATA_STACK_ERR_EN
    logic ovf_set, unf_set;

    assign ovf_set = armed && push && !pop && full;
    assign unf_set = armed && pop && !push && empty;

    // Clear has priority over a set event in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (err_clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_set)
                ovf <= 1'b1;
            if (unf_set)
                unf <= 1'b1;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf            = 1'b0;
    assign unf            = 1'b0;
`endif

endmodule

// File: doc/data_stack.md
DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 Parameter NBDATA, default 32: data word width in bits.
REQ-002 Parameter SDEPTH, default 16: stack entries; power of two, 2..1024.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 push  input  1  push request, driven by the instruction decoder dsp_push.
REQ-006 pop  input  1  pop request, driven by the instruction decoder dsp_pop.
REQ-007 din  input  NBDATA  word to push (accumulator value).
REQ-008 tos  output  NBDATA  registered top-of-stack word.
REQ-009 count  output  $clog2(SDEPTH)+1  number of valid entries, 0..SDEPTH.
REQ-010 empty  output  1  count == 0; full  output  1  count == SDEPTH.
REQ-011 err_clr  input  1  clears sticky error flags.
REQ-012 ovf, unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-013 Storage: SDEPTH x NBDATA array plus top pointer tp; tp always indexes the top entry and wraps modulo SDEPTH.
REQ-014 Push only (push=1, pop=0): tp <= tp+1, mem[tp+1] <= din, tos <= din, count <= min(count+1, SDEPTH).
REQ-015 Push when full: circular overwrite of the oldest entry; tp wraps; count stays SDEPTH; ovf set (REQ-024).
REQ-016 Pop only (pop=1, push=0) with count>1: tp <= tp-1, count <= count-1, tos <= mem[tp-1].
REQ-017 Pop with count==1: tp <= tp-1, count <= 0, tos <= 0.
REQ-018 Pop when empty: tp, count, tos unchanged; unf set (REQ-024).
REQ-019 Push and pop together: replace top; mem[tp] <= din, tos <= din, tp and count unchanged; if empty, acts as push only.
REQ-020 Neither asserted: all state holds.
REQ-021 Latency: tos, count, empty, full reflect an operation in the cycle after the sampling edge; back-to-back operations every cycle are supported with no stall.
REQ-022 empty and full are combinational decodes of registered count.

Reset
REQ-023 rst=1: tp=0, count=0, tos=0, ovf=0, unf=0 immediately and asynchronously; array contents not reset; an operation sampled in the same edge as reset release is ignored.

Configuration
REQ-024 Macro DATA_STACK_ERR_EN defined: ovf set on push-when-full (without simultaneous pop), unf set on pop-when-empty (without simultaneous push); both remain set until err_clr=1 for one cycle; err_clr wins over a simultaneous set event.
REQ-025 Macro DATA_STACK_ERR_EN undefined: ovf and unf are constant 0, err_clr ignored, no error logic synthesized; ports remain present.

Structure
REQ-026 Shared package data_stack_pkg holds default NBDATA, default SDEPTH, and the pointer-width/count-width constants derived from SDEPTH.
REQ-027 One sub-module stack_ram: single synchronous write port, one asynchronous read port addressed by tp-1; data_stack contains pointer, count, tos and flag logic.

Verification
REQ-028 Reset then push 0x11, 0x22, 0x33 on consecutive cycles -> tos 0x11, 0x22, 0x33 one cycle after each; count 3.
REQ-029 From REQ-028 state pop x3 -> tos 0x22, 0x11, 0x00; count 2, 1, 0; empty=1 after third pop.
REQ-030 SDEPTH=4: push 1..5 -> count 4, full=1, ovf=1 (macro on); then pop x4 -> tos 4, 3, 2, 0; value 1 never returned.
REQ-031 Empty stack, pop=1 -> tos 0, count 0, unf=1; err_clr pulse -> unf=0; with simultaneous set and err_clr -> unf=0.
REQ-032 count 2 (top 0x22), push=pop=1 with din 0xAA -> tos 0xAA, count 2; next pop -> tos 0x11 (below-top entry intact).
REQ-033 Assert rst mid-sequence with count 3 -> tos, count, ovf, unf 0 asynchronously; a push at the release edge ignored; next push 0x5 -> tos 0x5, count 1.
